// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory responder: size codes, FSM states, alignment check.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Halves must sit on even addresses, words on multiples of four; bytes never misalign.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SZ_HALF: return lsb[0];
      SZ_WORD: return (lsb != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables and replicated store word, load lane extraction and extension.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies every output.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  byte_off,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  // Replicate store data across all lanes so the byte enables alone pick the target bytes;
  // right-align the addressed lane of the read word and extend it.
  always_comb begin
    byte_en = 4'b0000;
    wword   = wdata;
    rdata   = 32'h0;
    shifted = rword >> {byte_off, 3'b000};
    case (size)
      SZ_BYTE: begin
        byte_en = 4'b0001 << byte_off;
        wword   = {4{wdata[7:0]}};
        rdata   = sign_ext ? {{24{shifted[7]}}, shifted[7:0]} : {24'h0, shifted[7:0]};
      end
      SZ_HALF: begin
        byte_en = byte_off[1] ? 4'b1100 : 4'b0011;
        wword   = {2{wdata[15:0]}};
        rdata   = sign_ext ? {{16{shifted[15]}}, shifted[15:0]} : {16'h0, shifted[15:0]};
      end
      SZ_WORD: begin
        byte_en = 4'b1111;
        rdata   = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store at a time with a programmable wait, one response per request.
// Latency: request accepted at edge T gives resp_valid after edge T+LATENCY+1.
// Backpressure: req_ready only in IDLE; the response is held stable until resp_ready is seen.
module data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH_WORDS);
  // Every request passes through WAIT; counting down from LATENCY gives exactly
  // LATENCY+1 edges between acceptance and the commit edge, including LATENCY = 0.
  localparam logic [3:0]  CNT_INIT   = 4'(LATENCY);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        commit;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] widx;
  logic [31:0]      rd_word;
  logic [31:0]      st_word;
  logic [31:0]      ld_data;
  logic [3:0]       byte_en;
  logic             acc_err;

  assign widx    = addr_q[IDX_W+1:2];
  assign rd_word = mem[widx];
  assign acc_err = (size_q == SZ_BAD) || is_misaligned(size_q, addr_q[1:0]) ||
                   (addr_q >= BYTE_LIMIT);

  mem_lane_align u_align (
    .byte_off (addr_q[1:0]),
    .size     (size_q),
    .sign_ext (signed_q),
    .wdata    (wdata_q),
    .rword    (rd_word),
    .byte_en  (byte_en),
    .wword    (st_word),
    .rdata    (ld_data)
  );

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Next-state logic: latch the request in IDLE, count down in WAIT, hold the response in RESP.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    commit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          cnt_d    = CNT_INIT;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      err_d   = acc_err;
      rdata_d = (acc_err || write_q) ? 32'h0 : ld_data;
    end
  end

  // Control and response registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      write_q  <= 1'b0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Storage keeps its contents across reset; a store only lands on its commit edge and never on error.
  always_ff @(posedge clk) begin
    if (!reset && commit && write_q && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[widx][8*i +: 8] <= st_word[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req_valid, req_write, req_signed, resp_ready, sel;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        rdy_a, vld_a, err_a, rdy_b, vld_b, err_b;
  logic [31:0] rdata_a, rdata_b;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  // sel = 0 steers traffic to the LATENCY=2 instance, sel = 1 to the LATENCY=0 instance.
  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(rdy_a),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(vld_a),
    .resp_ready(resp_ready & ~sel), .resp_rdata(rdata_a), .resp_err(err_a));

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_lat0 (
    .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_ready(rdy_b),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(vld_b),
    .resp_ready(resp_ready & sel), .resp_rdata(rdata_b), .resp_err(err_b));

  assign req_ready  = sel ? rdy_b   : rdy_a;
  assign resp_valid = sel ? vld_b   : vld_a;
  assign resp_rdata = sel ? rdata_b : rdata_a;
  assign resp_err   = sel ? err_b   : err_a;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;
  vec_t vecs[18];

  logic [7:0] model [1024];

  // Issue one request (called #1 after a posedge with the DUT idle), check latency and response.
  task automatic do_txn(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input string name, input int lat);
    exp_t e;
    int   n;
    e.rdata = exp_rd;
    e.err   = exp_err;
    sb_q.push_back(e);
    check({name, " req_ready"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!resp_valid && n < 40);
    check({name, " latency"}, 32'(n), 32'(lat + 1));
    e = sb_q.pop_front();
    if (resp_valid) begin
      check({name, " rdata"}, resp_rdata, e.rdata);
      check({name, " err"}, {31'h0, resp_err}, {31'h0, e.err});
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  // Random access checked against the byte-array model.
  task automatic rand_txn(input int k);
    logic [1:0]  sz;
    logic [31:0] addr, wdata, v;
    logic        wr, sg, err;
    int          nb;
    sz    = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    addr  = ($urandom_range(0, 19) == 0) ? 32'h400 + 32'($urandom_range(0, 15))
                                          : 32'($urandom_range(0, 1023));
    if ($urandom_range(0, 3) != 0) begin
      if (sz == 2'b01) addr[0] = 1'b0;
      if (sz == 2'b10) addr[1:0] = 2'b00;
    end
    wr    = 1'($urandom_range(0, 1));
    sg    = 1'($urandom_range(0, 1));
    wdata = $urandom;
    nb    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    err   = (sz == 2'b11) || (addr >= 32'h400) ||
            (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
    v = 32'h0;
    if (!err && wr) begin
      for (int i = 0; i < nb; i++) model[int'(addr[9:0]) + i] = wdata[8*i +: 8];
    end else if (!err) begin
      for (int i = 0; i < nb; i++) v[8*i +: 8] = model[int'(addr[9:0]) + i];
      if (sz == 2'b00 && sg) v = {{24{v[7]}}, v[7:0]};
      if (sz == 2'b01 && sg) v = {{16{v[15]}}, v[15:0]};
    end
    do_txn(wr, sz, sg, addr, wdata, v, err, $sformatf("rand%0d", k), 0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0; sel = 1'b0;
    for (int i = 0; i < 1024; i++) model[i] = 8'h0;

    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,  32'h12345678, 32'h0,        1'b0, "sw 0x10"};
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'h12345678, 1'b0, "lw 0x10"};
    vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h13,  32'h0,        32'h00000012, 1'b0, "lb 0x13"};
    vecs[3]  = '{1'b1, 2'b00, 1'b0, 32'h11,  32'hAAAAAA80, 32'h0,        1'b0, "sb 0x11"};
    vecs[4]  = '{1'b0, 2'b00, 1'b1, 32'h11,  32'h0,        32'hFFFFFF80, 1'b0, "lb 0x11"};
    vecs[5]  = '{1'b0, 2'b00, 1'b0, 32'h11,  32'h0,        32'h00000080, 1'b0, "lbu 0x11"};
    vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'h12348078, 1'b0, "lw 0x10 after sb"};
    vecs[7]  = '{1'b0, 2'b01, 1'b1, 32'h10,  32'h0,        32'hFFFF8078, 1'b0, "lh 0x10"};
    vecs[8]  = '{1'b0, 2'b01, 1'b0, 32'h12,  32'h0,        32'h00001234, 1'b0, "lhu 0x12"};
    vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h12,  32'h0,        32'h0,        1'b1, "lw misaligned"};
    vecs[10] = '{1'b1, 2'b01, 1'b0, 32'h401, 32'h1234,     32'h0,        1'b1, "sh 0x401"};
    vecs[11] = '{1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFEF00D, 32'h0,        1'b1, "sw 0x400"};
    vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h0,   32'h0,        32'h0,        1'b0, "lw 0x0"};
    vecs[13] = '{1'b0, 2'b11, 1'b0, 32'h10,  32'h0,        32'h0,        1'b1, "size 11"};
    vecs[14] = '{1'b1, 2'b10, 1'b0, 32'h20,  32'h11111111, 32'h0,        1'b0, "sw 0x20"};
    vecs[15] = '{1'b1, 2'b01, 1'b0, 32'h22,  32'h5555BEEF, 32'h0,        1'b0, "sh 0x22"};
    vecs[16] = '{1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'hBEEF1111, 1'b0, "lw 0x20"};
    vecs[17] = '{1'b0, 2'b01, 1'b1, 32'h22,  32'h0,        32'hFFFFBEEF, 1'b0, "lh 0x22"};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      check($sformatf("reset%0d req_ready", s),  {31'h0, req_ready},  32'h1);
      check($sformatf("reset%0d resp_valid", s), {31'h0, resp_valid}, 32'h0);
      check($sformatf("reset%0d rdata", s),      resp_rdata,          32'h0);
      check($sformatf("reset%0d err", s),        {31'h0, resp_err},   32'h0);
    end
    sel = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i])
      do_txn(vecs[i].wr, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].name, 2);

    // Response hold with resp_ready low for 5 cycles.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int n = 0; n < 40 && !resp_valid; n++) begin
      @(posedge clk); #1;
    end
    for (int c = 0; c < 5; c++) begin
      check($sformatf("hold%0d resp_valid", c), {31'h0, resp_valid}, 32'h1);
      check($sformatf("hold%0d rdata", c),      resp_rdata,          32'h12348078);
      check($sformatf("hold%0d req_ready", c),  {31'h0, req_ready},  32'h0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("hold release resp_valid", {31'h0, resp_valid}, 32'h0);
    check("hold release req_ready",  {31'h0, req_ready},  32'h1);

    // Reset while a store waits: no response, memory untouched.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h20;
    req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("abort%0d resp_valid", c), {31'h0, resp_valid}, 32'h0);
      @(posedge clk); #1;
    end
    do_txn(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hBEEF1111, 1'b0, "lw 0x20 after abort", 2);

    // Zero-latency instance: directed pair, then random traffic against the model.
    sel = 1'b1;
    #1;
    do_txn(1'b1, 2'b10, 1'b0, 32'h40, 32'hA5A5_0F0F, 32'h0, 1'b0, "l0 sw 0x40", 0);
    for (int i = 0; i < 4; i++) model[32'h40 + i] = 8'(32'hA5A5_0F0F >> (8 * i));
    do_txn(1'b0, 2'b00, 1'b1, 32'h43, 32'h0, 32'hFFFFFFA5, 1'b0, "l0 lb 0x43", 0);
    for (int k = 0; k < 300; k++) rand_txn(k);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
